// File: rtl/bit_vec_serializer.sv
// Serializes a WIDTH-bit vector onto a bit-serial valid/ready stream.
// An optional ones-counter reports the popcount after each completed vector.
module bit_vec_serializer #(
  parameter int unsigned WIDTH      = 6,
  parameter int unsigned MSB_FIRST  = 0,
  parameter int unsigned COUNT_ONES = 1,
  localparam int unsigned IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int unsigned CNTW = $clog2(WIDTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_bit,
  output logic [IDXW-1:0] out_index,
  output logic            out_last,
  output logic            ones_valid,
  output logic [CNTW-1:0] ones_count
);

  typedef enum logic {IDLE, SHIFT} state_e;

  localparam logic [IDXW-1:0] FIRST_IDX = (MSB_FIRST != 0) ? IDXW'(WIDTH - 1) : '0;
  localparam logic [IDXW-1:0] FINAL_IDX = (MSB_FIRST != 0) ? '0 : IDXW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] vec_q, vec_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             accept, xfer, at_final;

  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;
  assign at_final = (idx_q == FINAL_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      idx_q   <= FIRST_IDX;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          vec_d   = in_data;
          idx_d   = FIRST_IDX;
        end
      end
      SHIFT: begin
        if (xfer) begin
          if (at_final) begin
            state_d = IDLE;
            idx_d   = FIRST_IDX;
          end else if (MSB_FIRST != 0) begin
            idx_d = idx_q - IDXW'(1);
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Serial outputs are forced low in IDLE so a finished vector does not linger.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == SHIFT);
    out_bit   = 1'b0;
    out_index = '0;
    out_last  = 1'b0;
    if (state_q == SHIFT) begin
      out_bit   = vec_q[idx_q];
      out_index = idx_q;
      out_last  = at_final;
    end
  end

  if (COUNT_ONES != 0) begin : cnt
    logic [CNTW-1:0] acc_q, acc_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            pulse_q, pulse_d;

    always_ff @(posedge clk) begin
      if (rst) begin
        acc_q   <= '0;
        count_q <= '0;
        pulse_q <= 1'b0;
      end else begin
        acc_q   <= acc_d;
        count_q <= count_d;
        pulse_q <= pulse_d;
      end
    end

    always_comb begin
      acc_d   = acc_q;
      count_d = count_q;
      pulse_d = 1'b0;
      if (accept) begin
        acc_d = '0;
      end else if (xfer) begin
        acc_d = acc_q + CNTW'(out_bit);
        if (out_last) begin
          count_d = acc_d;
          pulse_d = 1'b1;
        end
      end
    end

    assign ones_valid = pulse_q;
    assign ones_count = count_q;
  end else begin : no_cnt
    assign ones_valid = 1'b0;
    assign ones_count = '0;
  end

endmodule

// File: tb/tb_bit_vec_serializer.sv
// Bench for bit_vec_serializer: four configurations, table-driven timing rows,
// hand sequences for corner cases and a queue scoreboard on the LSB-first instance.
module tb_bit_vec_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // u_lsb: WIDTH=6, LSB first, counter on
  logic a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_bit, a_out_last, a_ones_valid;
  logic [5:0] a_in_data;
  logic [2:0] a_out_index, a_ones_count;
  // u_msb: WIDTH=6, MSB first, counter on
  logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_bit, b_out_last, b_ones_valid;
  logic [5:0] b_in_data;
  logic [2:0] b_out_index, b_ones_count;
  // u_w1: WIDTH=1
  logic c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_bit, c_out_last, c_ones_valid;
  logic [0:0] c_in_data, c_out_index, c_ones_count;
  // u_w20: WIDTH=20, counter off
  logic d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_out_bit, d_out_last, d_ones_valid;
  logic [19:0] d_in_data;
  logic [4:0]  d_out_index, d_ones_count;

  bit_vec_serializer #(.WIDTH(6), .MSB_FIRST(0), .COUNT_ONES(1)) u_lsb (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_bit(a_out_bit),
    .out_index(a_out_index), .out_last(a_out_last), .ones_valid(a_ones_valid),
    .ones_count(a_ones_count));

  bit_vec_serializer #(.WIDTH(6), .MSB_FIRST(1), .COUNT_ONES(1)) u_msb (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_bit(b_out_bit),
    .out_index(b_out_index), .out_last(b_out_last), .ones_valid(b_ones_valid),
    .ones_count(b_ones_count));

  bit_vec_serializer #(.WIDTH(1), .MSB_FIRST(0), .COUNT_ONES(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_bit(c_out_bit),
    .out_index(c_out_index), .out_last(c_out_last), .ones_valid(c_ones_valid),
    .ones_count(c_ones_count));

  bit_vec_serializer #(.WIDTH(20), .MSB_FIRST(0), .COUNT_ONES(0)) u_w20 (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_bit(d_out_bit),
    .out_index(d_out_index), .out_last(d_out_last), .ones_valid(d_ones_valid),
    .ones_count(d_ones_count));

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input int unsigned info);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got %0d at %0t", name, info, $time);
  endtask

  // Scoreboard for u_lsb
  typedef struct packed { logic b; logic [2:0] idx; logic last; } bit_t;
  bit_t       sb_bits[$];
  logic [2:0] sb_ones[$];
  logic       stall_prev = 1'b0;
  logic [4:0] prev_out = '0;
  bit_t       exp_bit;
  logic [2:0] exp_ones;

  always @(negedge clk) begin
    if (rst) begin
      sb_bits.delete();
      sb_ones.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("hold", {a_out_valid, a_out_bit, a_out_index, a_out_last}, {1'b1, prev_out});
      if (a_out_valid && a_out_ready) begin
        if (sb_bits.size() == 0) fail_now("sb_extra_bit", a_out_index);
        else begin
          exp_bit = sb_bits.pop_front();
          check("sb_bit", {a_out_bit, a_out_index, a_out_last}, exp_bit);
        end
      end
      if (a_ones_valid) begin
        if (sb_ones.size() == 0) fail_now("sb_extra_ones", a_ones_count);
        else begin
          exp_ones = sb_ones.pop_front();
          check("sb_ones", a_ones_count, exp_ones);
        end
      end
      if (a_in_valid && a_in_ready) begin
        for (int i = 0; i < 6; i++) sb_bits.push_back('{a_in_data[i], 3'(i), (i == 5)});
        sb_ones.push_back(3'($countones(a_in_data)));
      end
      stall_prev = a_out_valid && !a_out_ready;
      prev_out   = {a_out_bit, a_out_index, a_out_last};
    end
  end

  // mode 0: out_ready high; 1: pattern 1,0,0,1; 2: random
  task automatic lsb_send(input logic [5:0] vec, input int unsigned mode);
    int unsigned n = 0;
    while (!a_in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) fail_now("lsb_wait_ready", n);
    a_in_valid = 1'b1;
    a_in_data  = vec;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    a_in_data  = 6'($urandom);
    n = 0;
    while ((sb_bits.size() != 0 || sb_ones.size() != 0) && n < 200) begin
      case (mode)
        0:       a_out_ready = 1'b1;
        1:       a_out_ready = ((n % 4) == 0) || ((n % 4) == 3);
        default: a_out_ready = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) fail_now("lsb_drain_timeout", n);
  endtask

  typedef struct {
    logic       iv;
    logic [5:0] din;
    logic       ordy;
    logic       e_rdy, e_vld, e_bit;
    logic [2:0] e_idx;
    logic       e_last, e_ov;
    logic [2:0] e_cnt;
  } row_t;
  row_t tbl [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] mvec;
    logic       odd;

    tbl[0] = '{1'b1, 6'b000001, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0};
    tbl[1] = '{1'b0, 6'b111110, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0};
    tbl[2] = '{1'b0, 6'b111110, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 3'd0};
    tbl[3] = '{1'b0, 6'b111110, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 3'd0};
    tbl[4] = '{1'b0, 6'b111110, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 3'd0};
    tbl[5] = '{1'b0, 6'b111110, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 3'd0};
    tbl[6] = '{1'b0, 6'b111110, 1'b1, 1'b0, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0, 3'd0};
    tbl[7] = '{1'b0, 6'b000000, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1};
    tbl[8] = '{1'b0, 6'b000000, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd1};

    rst = 1'b1;
    a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
    b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
    c_in_valid = 0; c_in_data = '0; c_out_ready = 0;
    d_in_valid = 0; d_in_data = '0; d_out_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a", {a_in_ready, a_out_valid, a_out_bit, a_out_index, a_out_last, a_ones_valid, a_ones_count}, 11'b100_0000_0000);
    check("rst_b", {b_in_ready, b_out_valid, b_out_bit, b_out_index, b_out_last, b_ones_valid, b_ones_count}, 11'b100_0000_0000);
    check("rst_c", {c_in_ready, c_out_valid, c_out_bit, c_out_index, c_out_last, c_ones_valid, c_ones_count}, 7'b100_0000);
    check("rst_d", {d_in_ready, d_out_valid, d_out_bit, d_out_index, d_out_last, d_ones_valid, d_ones_count}, 15'b100_0000_0000_0000);
    @(posedge clk); #1;
    rst = 1'b0;

    // Cycle-accurate timing of one LSB-first vector
    for (int i = 0; i < 9; i++) begin
      a_in_valid = tbl[i].iv; a_in_data = tbl[i].din; a_out_ready = tbl[i].ordy;
      @(negedge clk);
      check($sformatf("tbl_row%0d", i),
            {a_in_ready, a_out_valid, a_out_bit, a_out_index, a_out_last, a_ones_valid, a_ones_count},
            {tbl[i].e_rdy, tbl[i].e_vld, tbl[i].e_bit, tbl[i].e_idx, tbl[i].e_last, tbl[i].e_ov, tbl[i].e_cnt});
      @(posedge clk); #1;
    end

    // MSB-first order
    mvec = 6'b101100;
    b_in_valid = 1'b1; b_in_data = mvec; b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0; b_in_data = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("msb_bit%0d", k), {b_out_valid, b_out_bit, b_out_index, b_out_last},
            {1'b1, mvec[5 - k], 3'(5 - k), (k == 5)});
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("msb_ones", {b_ones_valid, b_ones_count}, {1'b1, 3'd3});
    @(posedge clk); #1;

    // WIDTH=1 with in_valid held high
    c_in_valid = 1'b1; c_in_data = 1'b1; c_out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      odd = 1'(k % 2);
      @(negedge clk);
      check($sformatf("w1_cyc%0d", k),
            {c_in_ready, c_out_valid, c_out_bit, c_out_index, c_out_last, c_ones_valid, c_ones_count},
            {~odd, odd, odd, 1'b0, odd, (~odd && k > 0), (k >= 2)});
      @(posedge clk); #1;
    end
    c_in_valid = 1'b0;

    // WIDTH=20 with counter removed
    d_in_valid = 1'b1; d_in_data = 20'hFFFFF; d_out_ready = 1'b1;
    @(posedge clk); #1;
    d_in_valid = 1'b0; d_in_data = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check($sformatf("w20_bit%0d", k), {d_out_valid, d_out_bit, d_out_index, d_out_last, d_ones_valid, d_ones_count},
            {1'b1, 1'b1, 5'(k), (k == 19), 1'b0, 5'd0});
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("w20_done", {d_out_valid, d_in_ready, d_ones_valid, d_ones_count}, {1'b0, 1'b1, 1'b0, 5'd0});
    @(posedge clk); #1;

    // Reset on the third SHIFT cycle
    a_in_valid = 1'b1; a_in_data = 6'b111111; a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid", {a_out_valid, a_in_ready, a_ones_valid, a_ones_count}, {1'b0, 1'b1, 1'b0, 3'd0});
    @(negedge clk);
    check("rst_nopulse", {a_ones_valid, a_out_valid}, 2'b00);
    @(posedge clk); #1;
    lsb_send(6'b000011, 0);

    // Backpressure, then random traffic
    lsb_send(6'b110010, 1);
    for (int v = 0; v < 8; v++) lsb_send(6'($urandom), 2);
    lsb_send(6'b111111, 1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("sb_drain", sb_bits.size() + sb_ones.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bit_vec_serializer.md
Name: bit_vec_serializer

Overview:
- Consumes a parallel bit-vector of WIDTH bits through a valid/ready handshake and emits it one bit per transfer on a bit-serial valid/ready stream.
- It is the read-side counterpart of blocks that build wide vectors bit-by-bit from separate assignments.
- An optional generate-selected population counter reports the number of ones sent once each vector completes.

Parameters:
- WIDTH, 6, vector width in bits; legal range is 1 or more.
- MSB_FIRST, 0, 0 sends bit 0 first; 1 sends bit WIDTH-1 first.
- COUNT_ONES, 1, 1 instantiates the ones-counter generate block; 0 ties its outputs to 0.
- Derived localparams:
  - IDXW = (WIDTH>1) ? $clog2(WIDTH) : 1
  - CNTW = $clog2(WIDTH+1)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  in_data is presented
- in_ready  output  1  block can accept a vector
- in_data  input  WIDTH  vector to serialize
- out_valid  output  1  out_bit is valid
- out_ready  input  1  downstream accepts out_bit
- out_bit  output  1  current serial bit
- out_index  output  IDXW  bit position of out_bit within the vector
- out_last  output  1  current bit is the final bit of the vector
- ones_valid  output  1  one-cycle pulse: ones_count is valid
- ones_count  output  CNTW  number of 1 bits in the completed vector

Behaviour:
- Reset:
  - rst is sampled on a clk edge and overrides all other inputs in that cycle.
  - After reset: state=IDLE, in_ready=1, out_valid=0, out_bit=0, out_index=0, out_last=0, ones_valid=0, ones_count=0, shift register=0.
- FSM, two states:
  - IDLE:
    - in_ready=1, out_valid=0.
    - When in_valid&&in_ready, capture in_data and go to SHIFT.
  - SHIFT:
    - in_ready=0, out_valid=1.
    - The transfer condition is out_valid&&out_ready.
    - On a non-final transfer, advance to the next bit.
    - On the final transfer (out_last=1), return to IDLE.
- Latency:
  - The first bit is valid the cycle after the accept edge.
  - With out_ready held high, one bit transfers per cycle.
  - in_ready returns 1 the cycle after the final transfer, so there are no back-to-back vectors without a gap cycle.
  - Minimum period per vector: WIDTH+1 cycles.
- Bit order:
  - MSB_FIRST=0: out_index counts 0..WIDTH-1 and out_bit=vector[out_index].
  - MSB_FIRST=1: out_index counts WIDTH-1..0 and out_bit=vector[out_index].
  - out_last=1 exactly when the final index of the chosen order is presented.
- WIDTH=1: the single bit has out_index=0 and out_last=1 on the first SHIFT cycle.
- Backpressure:
  - While out_valid=1 and out_ready=0, out_bit, out_index and out_last hold stable.
  - in_data changes after the accept edge have no effect.
- Ones counter (COUNT_ONES=1, generate block named cnt):
  - The accumulator clears on accept.
  - It adds out_bit on each transfer.
  - The cycle after the final transfer: ones_valid=1 for exactly one cycle, and ones_count holds the total until the next final transfer or reset.
  - Width rule: the count never wraps, since CNTW covers the value WIDTH.
- COUNT_ONES=0: ones_valid=0 and ones_count=0 permanently.
- X/Z in captured data propagates unchanged to out_bit. The counter's behaviour on X/Z input is not specified.
- Reset mid-vector: the remaining bits are discarded, no ones_valid pulse occurs, and the block is in IDLE the cycle after reset.

Test Plan:
- WIDTH=6, MSB_FIRST=0, out_ready=1, in_data=6'b000001 accepted at cycle 0:
  - cycles 1..6 produce out_bit 1,0,0,0,0,0 with out_index 0..5.
  - out_last=1 only at cycle 6.
  - cycle 7: ones_valid=1 with ones_count=1, and in_ready=1.
- MSB_FIRST=1, in_data=6'b101100: bits are 1,0,1,1,0,0 with out_index 5..0; ones_count=3.
- Backpressure on 6'b110010 with out_ready toggled 1,0,0,1,...:
  - outputs hold during stalls.
  - the received sequence is exactly 0,1,0,0,1,1 (MSB_FIRST=0).
  - ones_count=3.
- Reset asserted on the third SHIFT cycle of 6'b111111:
  - the next cycle has out_valid=0, in_ready=1, ones_valid=0.
  - a new vector 6'b000011 then serializes correctly with ones_count=2.
- WIDTH=1, in_data=1:
  - one transfer with out_index=0 and out_last=1.
  - ones_count=1 next cycle.
  - in_valid held high re-accepts every 2 cycles.
- WIDTH=20, COUNT_ONES=0, in_data=20'hFFFFF:
  - 20 ones are emitted with out_index reaching 19.
  - ones_valid and ones_count stay 0 throughout.
